fir_decim_fifo: RTL
===================

Name: fir_decim_fifo

Overview:
- Downstream consumer of the 8-bit FIR output stream. Takes one filtered sample per enabled cycle and decimates by a run-time factor 1..16.
- Buffers the kept samples in a small first-word-fall-through FIFO.
- Hands the samples to the next stage over a valid/ready interface.
- Flags samples dropped because the downstream stalled.

Parameters:
- DATA_W, 8, sample width; matches the filter output.
- FIFO_DEPTH, 4, FIFO entries; power of 2, minimum 2.
- LVL_W, 3, width of the level output; must equal log2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_W  filtered sample from the FIR stage.
- in_en  in  1  in_data is a new sample this cycle; tied high when the filter runs every clock.
- decim  in  4  decimation factor minus 1 (0 means keep every sample, 15 means keep 1 in 16).
- out_data  out  DATA_W  FIFO head sample.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  downstream accepts out_data this cycle.
- level  out  LVL_W  current FIFO occupancy, 0..FIFO_DEPTH.
- ovf  out  1  sticky flag: at least one kept sample was dropped.
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset (rst_n low, asynchronous): phase=0, d_eff=0, FIFO empty, out_valid=0, out_data=0, level=0, ovf=0. Reset mid-operation discards all buffered samples.
- Phase counter (4 bits):
  - Advances only on in_en.
  - On in_en with phase==0: the sample is "kept" (push request) and d_eff<=decim.
  - phase==d_eff wraps phase to 0; otherwise phase increments.
  - Result: first sample after reset is kept, then every (d_eff+1)-th enabled sample.
  - decim changes take effect only at the next kept sample; the current window completes with the old factor.
- Push: a push request writes in_data at the tail if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the sample is dropped and ovf<=1.
- Pop: occurs when out_valid && out_ready; the head advances.
- Simultaneous push and pop:
  - Empty FIFO: no pop is possible, so push only.
  - Non-empty FIFO: level is unchanged and both operations complete.
- Output timing:
  - First-word-fall-through. out_data always shows the head entry and holds stable while out_valid && !out_ready.
  - Latency from a kept in_data at edge k to out_valid=1 with that data is 1 cycle (visible after edge k).
- Pointers: read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. level is a registered count updated with push/pop; full is level==FIFO_DEPTH.
- out_data: reads 0 after reset until the first push; when empty, it holds the last popped value (don't-care to downstream).
- ovf: ovf_clr clears it on the next edge. A drop in the same cycle as ovf_clr wins, so ovf stays 1.
- No arithmetic is performed on samples; data passes bit-exact.

Optional Feature:
- Macro: FIR_DECIM_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt [7:0], reset 0.
  - Increments by 1 per dropped sample and saturates at 255.
  - Cleared by ovf_clr; a drop in the clear cycle gives drop_cnt=1.
- Not defined: the port and counter do not exist; ovf behaviour is identical.

Test Plan:
- Passthrough: decim=0, in_en=1, out_ready=1, in_data=1,2,3,... -> out_data sequence 1,2,3,... with out_valid from 1 cycle after the first sample; level stays ≤1; ovf=0.
- Decimate-by-4: decim=3, in_data=0..15 on consecutive cycles, out_ready=1 -> outputs exactly 0,4,8,12.
- Factor change mid-window: decim=3; after sample 1 set decim=1; in_data=0..9 -> kept samples 0,4,6,8.
- Backpressure/overflow: decim=0, out_ready=0, push 6 samples 10..15 -> level=4, out_data=10, ovf=1 (drop_cnt=2 if enabled). Then out_ready=1 -> pops 10,11,12,13, then out_valid=0.
- Full with simultaneous push+pop: FIFO full (level=4), out_ready=1, kept sample 0x55 -> level stays 4, no ovf, 0x55 later emerges in order.
- Async reset mid-stream: assert rst_n low between edges with level=3, ovf=1 -> out_valid, level, ovf and phase go to 0 immediately. After release, the first sample is kept.

Source files
------------

// File: rtl/fir_decim_fifo.sv
// Run-time decimator (keep 1 of decim+1 enabled samples) feeding a small FWFT FIFO with valid/ready output.
// Optional FIR_DECIM_DROP_CNT_EN adds a saturating drop counter output alongside the sticky ovf flag.
module fir_decim_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_en,
  input  logic [3:0]        decim,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LVL_W-1:0]  level,
  output logic              ovf,
  input  logic              ovf_clr
`ifdef FIR_DECIM_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [3:0]        r_phase;
  logic [3:0]        r_deff;
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [LVL_W-1:0]  r_level;
  logic [DATA_W-1:0] r_head;
  logic              r_ovf;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];

  logic [3:0]        w_deff_cur;
  logic              w_keep;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [AW-1:0]     w_rptr_nxt;

  // A new window starts at phase 0, so the wrap compare must already use the freshly sampled factor.
  assign w_deff_cur = (r_phase == 4'd0) ? decim : r_deff;
  assign w_keep     = in_en && (r_phase == 4'd0);
  assign w_full     = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop      = out_valid && out_ready;
  assign w_push     = w_keep && (!w_full || w_pop);
  assign w_drop     = w_keep && !w_push;
  assign w_rptr_nxt = r_rptr + AW'(1);

  assign out_valid = (r_level != '0);
  assign out_data  = r_head;
  assign level     = r_level;
  assign ovf       = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= 4'd0;
      r_deff  <= 4'd0;
    end else if (in_en) begin
      if (r_phase == 4'd0) r_deff <= decim;
      r_phase <= (r_phase == w_deff_cur) ? 4'd0 : r_phase + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= w_rptr_nxt;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Registered head: holds the last popped value when the FIFO drains instead of exposing stale memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
    end else if (r_level == '0) begin
      if (w_push) r_head <= in_data;
    end else if (w_pop) begin
      if (r_level >= LVL_W'(2)) r_head <= r_mem[w_rptr_nxt];
      else if (w_push)          r_head <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (ovf_clr) r_ovf <= 1'b0;
  end

`ifdef FIR_DECIM_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_drop_cnt <= 8'd0;
    else if (ovf_clr)                       r_drop_cnt <= {7'd0, w_drop};
    else if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule
